rh_axi4_wr_slave: RTL and testbench

AXI4 write-channel responder (slave end) for the VIP's DUT-side model. Accepts one write burst at a time: AW handshake, then W beats, then B response. Generates per-beat addresses for FIXED/INCR/WRAP bursts and drives a simple word-wide backing-memory write port. Complements the master-side driver in the same AXI4 VIP.

---
 rtl/rh_axi4_wr_slave.sv | 160 ++++++++++++++++
 tb/tb_rh_axi4_wr_slave.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rh_axi4_wr_slave.sv
// AXI4 write-channel slave: one burst at a time (AW -> W beats -> B) driving a word-wide memory write port.
// Optional WLAST consistency check enabled by defining RH_AXI4_WR_SLV_WLAST_CHK_EN.
module rh_axi4_wr_slave #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int IW = 4,
    parameter int MEM_AW = 10,
    parameter logic [AW-1:0] BASE = '0,
    localparam int NB = DW / 8
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [IW-1:0]     AWID,
    input  logic [AW-1:0]     AWADDR,
    input  logic [7:0]        AWLEN,
    input  logic [2:0]        AWSIZE,
    input  logic [1:0]        AWBURST,
    input  logic              AWLOCK,
    input  logic              WVALID,
    output logic              WREADY,
    input  logic [DW-1:0]     WDATA,
    input  logic [NB-1:0]     WSTRB,
    input  logic              WLAST,
    output logic              BVALID,
    input  logic              BREADY,
    output logic [IW-1:0]     BID,
    output logic [1:0]        BRESP,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic [NB-1:0]     mem_wstrb
);
    localparam int LOG_NB = $clog2(NB);
    localparam logic [2:0] LOG_NB3 = 3'(LOG_NB);
    localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] id_q;
    logic [AW-1:0] cur_addr, wrap_lo, wrap_end;
    logic [7:0]    len_q, beat_cnt;
    logic [2:0]    size_q;
    logic [1:0]    burst_q;
    logic          burst_bad, err;

    // Exclusive access is not supported; a locked write is just a normal write.
    logic unused_lock;
    assign unused_lock = AWLOCK;

    // Burst-level legality, evaluated on the AW request itself
    logic [AW-1:0] aw_bytes, aw_wlen;
    logic          aw_bad;
    always_comb begin
        aw_bytes = ONE << AWSIZE;
        aw_wlen  = aw_bytes * ({{(AW-8){1'b0}}, AWLEN} + ONE);
        aw_bad   = (AWSIZE > LOG_NB3) || (AWBURST == 2'b11) ||
                   ((AWBURST == 2'b10) &&
                    (!(AWLEN inside {8'd1, 8'd3, 8'd7, 8'd15}) || ((AWADDR & (aw_bytes - ONE)) != '0)));
    end

    logic [AW-1:0] bytes, off, next_addr, inc_addr;
    logic          range_err, beat_err, last_beat, wlast_bad;
    always_comb begin
        bytes     = ONE << size_q;
        off       = cur_addr - BASE;
        range_err = (cur_addr < BASE) || ((off >> (LOG_NB + MEM_AW)) != '0);
        beat_err  = burst_bad | range_err;
        last_beat = (beat_cnt == len_q);
        inc_addr  = cur_addr + bytes;
        case (burst_q)
            2'b01:   next_addr = (cur_addr & ~(bytes - ONE)) + bytes;
            2'b10:   next_addr = (inc_addr == wrap_end) ? wrap_lo : inc_addr;
            default: next_addr = cur_addr;
        endcase
    end

`ifdef RH_AXI4_WR_SLV_WLAST_CHK_EN
    assign wlast_bad = (WLAST != last_beat);
`else
    logic unused_wlast;
    assign unused_wlast = WLAST;
    assign wlast_bad    = 1'b0;
`endif

    assign mem_we    = WVALID & WREADY & ~beat_err;
    assign mem_addr  = MEM_AW'(off >> LOG_NB);
    assign mem_wdata = WDATA;
    assign mem_wstrb = WSTRB;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state     <= S_IDLE;
            AWREADY   <= 1'b0;
            WREADY    <= 1'b0;
            BVALID    <= 1'b0;
            BID       <= '0;
            BRESP     <= 2'b00;
            id_q      <= '0;
            cur_addr  <= '0;
            wrap_lo   <= '0;
            wrap_end  <= '0;
            len_q     <= '0;
            beat_cnt  <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            burst_bad <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!AWREADY) begin
                        AWREADY <= 1'b1;
                    end else if (AWVALID) begin
                        AWREADY   <= 1'b0;
                        WREADY    <= 1'b1;
                        state     <= S_DATA;
                        id_q      <= AWID;
                        cur_addr  <= AWADDR;
                        // Wrap window only meaningful for legal WRAP bursts (power-of-two length)
                        wrap_lo   <= AWADDR & ~(aw_wlen - ONE);
                        wrap_end  <= (AWADDR & ~(aw_wlen - ONE)) + aw_wlen;
                        len_q     <= AWLEN;
                        size_q    <= AWSIZE;
                        burst_q   <= AWBURST;
                        beat_cnt  <= '0;
                        burst_bad <= aw_bad;
                        err       <= aw_bad;
                    end
                end
                S_DATA: begin
                    if (WVALID) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        cur_addr <= next_addr;
                        err      <= err | beat_err | wlast_bad;
                        if (last_beat) begin
                            WREADY <= 1'b0;
                            BVALID <= 1'b1;
                            BID    <= id_q;
                            BRESP  <= (err | beat_err | wlast_bad) ? 2'b10 : 2'b00;
                            state  <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (BREADY) begin
                        BVALID  <= 1'b0;
                        AWREADY <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rh_axi4_wr_slave.sv
// Directed bench for rh_axi4_wr_slave: cycle-exact AW/W/B sequences with hand-computed expectations.
module tb_rh_axi4_wr_slave;
    logic        ACLK = 1'b0, ARESET = 1'b1;
    logic        AWVALID = 1'b0, AWREADY;
    logic [3:0]  AWID = '0;
    logic [31:0] AWADDR = '0;
    logic [7:0]  AWLEN = '0;
    logic [2:0]  AWSIZE = '0;
    logic [1:0]  AWBURST = '0;
    logic        AWLOCK = 1'b0;
    logic        WVALID = 1'b0, WREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WLAST = 1'b0;
    logic        BVALID, BREADY = 1'b0;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    int vectors = 0;
    int miscompares = 0;

`ifdef RH_AXI4_WR_SLV_WLAST_CHK_EN
    localparam logic [1:0] WLAST_RESP = 2'b10;
`else
    localparam logic [1:0] WLAST_RESP = 2'b00;
`endif

    rh_axi4_wr_slave dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWADDR(AWADDR),
        .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWLOCK(AWLOCK),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst, input logic lock);
        @(negedge ACLK);
        chk("awready_idle", AWREADY, 1);
        chk("wready_idle", WREADY, 0);
        AWVALID = 1'b1; AWID = id; AWADDR = addr; AWLEN = len;
        AWSIZE = size; AWBURST = burst; AWLOCK = lock;
        @(posedge ACLK); #1;
        AWVALID = 1'b0; AWLOCK = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic [3:0] strb, input logic last,
                        input logic exp_we, input logic [9:0] exp_a);
        @(negedge ACLK);
        chk("wready_data", WREADY, 1);
        chk("awready_data", AWREADY, 0);
        WVALID = 1'b1; WDATA = d; WSTRB = strb; WLAST = last;
        #1;
        chk("mem_we", mem_we, exp_we);
        if (exp_we) begin
            chk("mem_addr", mem_addr, exp_a);
            chk("mem_wdata", mem_wdata, d);
            chk("mem_wstrb", mem_wstrb, strb);
        end
        @(posedge ACLK); #1;
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    task automatic resp(input logic [3:0] id, input logic [1:0] r, input int hold);
        @(negedge ACLK);
        chk("bvalid", BVALID, 1);
        chk("bid", BID, id);
        chk("bresp", BRESP, r);
        chk("wready_resp", WREADY, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge ACLK);
            chk("bvalid_hold", BVALID, 1);
            chk("bid_hold", BID, id);
            chk("bresp_hold", BRESP, r);
        end
        BREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
        @(negedge ACLK);
        chk("bvalid_done", BVALID, 0);
        chk("awready_after_b", AWREADY, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_awready", AWREADY, 0);
        chk("rst_wready", WREADY, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_bid", BID, 0);
        chk("rst_bresp", BRESP, 0);
        chk("rst_mem_we", mem_we, 0);
        @(negedge ACLK);
        ARESET = 1'b0;
        #1 chk("awready_before_edge", AWREADY, 0);

        // INCR 0x10 len 3 size 2 -> words 4..7
        aw(4'd5, 32'h10, 8'd3, 3'd2, 2'b01, 1'b0);
        beat(32'hA0A0_0001, 4'hF, 1'b0, 1'b1, 10'h004);
        beat(32'hA0A0_0002, 4'h3, 1'b0, 1'b1, 10'h005);
        beat(32'hA0A0_0003, 4'hC, 1'b0, 1'b1, 10'h006);
        beat(32'hA0A0_0004, 4'hF, 1'b1, 1'b1, 10'h007);
        resp(4'd5, 2'b00, 0);

        // WRAP 0x38 len 3: window 0x30..0x3F -> E,F,C,D
        aw(4'd1, 32'h38, 8'd3, 3'd2, 2'b10, 1'b0);
        beat(32'hB000_0001, 4'hF, 1'b0, 1'b1, 10'h00E);
        beat(32'hB000_0002, 4'hF, 1'b0, 1'b1, 10'h00F);
        beat(32'hB000_0003, 4'hF, 1'b0, 1'b1, 10'h00C);
        beat(32'hB000_0004, 4'hF, 1'b1, 1'b1, 10'h00D);
        resp(4'd1, 2'b00, 0);

        // WRAP with illegal len 2: all beats accepted, none written
        aw(4'd2, 32'h30, 8'd2, 3'd2, 2'b10, 1'b0);
        beat(32'hC000_0001, 4'hF, 1'b0, 1'b0, 10'h000);
        beat(32'hC000_0002, 4'hF, 1'b0, 1'b0, 10'h000);
        beat(32'hC000_0003, 4'hF, 1'b1, 1'b0, 10'h000);
        resp(4'd2, 2'b10, 0);

        // FIXED 0x20 len 2 -> word 8 three times; B held for 5 cycles
        aw(4'd3, 32'h20, 8'd2, 3'd2, 2'b00, 1'b0);
        beat(32'hD000_0001, 4'hF, 1'b0, 1'b1, 10'h008);
        beat(32'hD000_0002, 4'hF, 1'b0, 1'b1, 10'h008);
        beat(32'hD000_0003, 4'hF, 1'b1, 1'b1, 10'h008);
        resp(4'd3, 2'b00, 5);

        // INCR crossing end of memory at 0x1000
        aw(4'd4, 32'hFF8, 8'd3, 3'd2, 2'b01, 1'b0);
        beat(32'hE000_0001, 4'hF, 1'b0, 1'b1, 10'h3FE);
        beat(32'hE000_0002, 4'hF, 1'b0, 1'b1, 10'h3FF);
        beat(32'hE000_0003, 4'hF, 1'b0, 1'b0, 10'h000);
        beat(32'hE000_0004, 4'hF, 1'b1, 1'b0, 10'h000);
        resp(4'd4, 2'b10, 0);

        // SIZE 3 on a 32-bit bus
        aw(4'd6, 32'h0, 8'd1, 3'd3, 2'b01, 1'b0);
        beat(32'hF000_0001, 4'hF, 1'b0, 1'b0, 10'h000);
        beat(32'hF000_0002, 4'hF, 1'b1, 1'b0, 10'h000);
        resp(4'd6, 2'b10, 0);

        // Reserved burst type
        aw(4'd8, 32'h0, 8'd0, 3'd2, 2'b11, 1'b0);
        beat(32'h1111_0001, 4'hF, 1'b1, 1'b0, 10'h000);
        resp(4'd8, 2'b10, 0);

        // Locked single-beat write is a plain OKAY write
        aw(4'd7, 32'h40, 8'd0, 3'd2, 2'b01, 1'b1);
        beat(32'h2222_0001, 4'hF, 1'b1, 1'b1, 10'h010);
        resp(4'd7, 2'b00, 0);

        // Reset in the middle of a 4-beat burst
        aw(4'd9, 32'h0, 8'd3, 3'd2, 2'b01, 1'b0);
        beat(32'h3333_0001, 4'hF, 1'b0, 1'b1, 10'h000);
        beat(32'h3333_0002, 4'hF, 1'b0, 1'b1, 10'h001);
        @(negedge ACLK);
        WVALID = 1'b1;
        ARESET = 1'b1;
        #1;
        chk("midrst_awready", AWREADY, 0);
        chk("midrst_wready", WREADY, 0);
        chk("midrst_bvalid", BVALID, 0);
        chk("midrst_bid", BID, 0);
        chk("midrst_mem_we", mem_we, 0);
        @(negedge ACLK);
        ARESET = 1'b0;
        WVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            chk("midrst_no_b", BVALID, 0);
        end
        aw(4'd10, 32'h44, 8'd0, 3'd2, 2'b01, 1'b0);
        beat(32'h4444_0001, 4'hF, 1'b1, 1'b1, 10'h011);
        resp(4'd10, 2'b00, 0);

        // Early WLAST on beat 0: both beats still written
        aw(4'd11, 32'h50, 8'd1, 3'd2, 2'b01, 1'b0);
        beat(32'h5555_0001, 4'hF, 1'b1, 1'b1, 10'h014);
        beat(32'h5555_0002, 4'hF, 1'b1, 1'b1, 10'h015);
        resp(4'd11, WLAST_RESP, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
